// File: rtl/cpu_pkg.sv
// Shared CS3220 pipeline definitions: PC/branch unit state encoding and core-wide widths.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0040;

  typedef enum logic [1:0] {
    PCU_RUN   = 2'd0,
    PCU_FLUSH = 2'd1,
    PCU_HALT  = 2'd2
  } pcu_state_e;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Execute-stage control-flow bus between the pipeline and pc_branch_unit.
// Carries the stats counters when BRANCH_STATS_EN is defined.
interface pc_branch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  stall;
  logic                  ex_valid;
  logic                  ex_is_branch;
  logic                  ex_is_jal;
  logic                  ex_is_halt;
  logic                  alu_compare;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic [DATA_WIDTH-1:0] ex_rs1;
  logic [DATA_WIDTH-1:0] pc;
  logic                  fetch_valid;
  logic                  flush;
  logic [DATA_WIDTH-1:0] link_addr;
  logic                  halted;
`ifdef BRANCH_STATS_EN
  logic [31:0]           stat_taken;
  logic [31:0]           stat_flush_cycles;

  modport master (
    output stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_halt, alu_compare,
           ex_pc, ex_imm, ex_rs1,
    input  pc, fetch_valid, flush, link_addr, halted, stat_taken, stat_flush_cycles
  );

  modport slave (
    input  stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_halt, alu_compare,
           ex_pc, ex_imm, ex_rs1,
    output pc, fetch_valid, flush, link_addr, halted, stat_taken, stat_flush_cycles
  );
`else
  modport master (
    output stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_halt, alu_compare,
           ex_pc, ex_imm, ex_rs1,
    input  pc, fetch_valid, flush, link_addr, halted
  );

  modport slave (
    input  stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_halt, alu_compare,
           ex_pc, ex_imm, ex_rs1,
    output pc, fetch_valid, flush, link_addr, halted
  );
`endif

endinterface

// File: rtl/pcu_target_calc.sv
// Combinational redirect target and JAL link address.
// Branch: ex_pc + 4 + imm*4; JAL: rs1 + imm*4; targets are word-aligned.
module pcu_target_calc
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH
) (
  input  logic                  is_jal,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_imm,
  input  logic [DATA_WIDTH-1:0] ex_rs1,
  output logic [DATA_WIDTH-1:0] target_c,
  output logic [DATA_WIDTH-1:0] link_c
);

  logic [DATA_WIDTH-1:0] offset;
  logic [DATA_WIDTH-1:0] br_sum;
  logic [DATA_WIDTH-1:0] jal_sum;
  logic [DATA_WIDTH-1:0] sel_sum;

  assign offset  = ex_imm << 2;
  assign link_c  = ex_pc + DATA_WIDTH'(4);
  assign br_sum  = link_c + offset;
  assign jal_sum = ex_rs1 + offset;
  assign sel_sum = is_jal ? jal_sum : br_sum;

  // JAL base may be unaligned; force the fetch target onto a word boundary
  assign target_c = {sel_sum[DATA_WIDTH-1:2], 2'b00};

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register, branch/JAL redirect and timed flush, halt handling.
// Optional BRANCH_STATS_EN adds saturating taken-redirect and flush-cycle counters.
module pc_branch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = cpu_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(cpu_pkg::RESET_PC),
  parameter int unsigned           FLUSH_DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  pc_branch_unit_if.slave  bus
);

  localparam int unsigned CNT_W = 3;

  pcu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  flush_q, flush_d;
  logic                  halted_q, halted_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic [DATA_WIDTH-1:0] target_c;
  logic [DATA_WIDTH-1:0] link_c;

  pcu_target_calc #(.DATA_WIDTH(DATA_WIDTH)) u_target_calc (
    .is_jal   (bus.ex_is_jal),
    .ex_pc    (bus.ex_pc),
    .ex_imm   (bus.ex_imm),
    .ex_rs1   (bus.ex_rs1),
    .target_c (target_c),
    .link_c   (link_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PCU_RUN;
      pc_q          <= RESET_PC;
      cnt_q         <= '0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
      fetch_valid_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
      halted_q      <= halted_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Execute inputs are only honoured in RUN; halt beats JAL beats branch
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    flush_d       = 1'b0;
    halted_d      = halted_q;
    fetch_valid_d = fetch_valid_q;
    case (state_q)
      PCU_RUN: begin
        if (bus.ex_valid && bus.ex_is_halt) begin
          state_d       = PCU_HALT;
          halted_d      = 1'b1;
          fetch_valid_d = 1'b0;
          flush_d       = 1'b1;
        end else if (bus.ex_valid &&
                     (bus.ex_is_jal || (bus.ex_is_branch && bus.alu_compare))) begin
          state_d = PCU_FLUSH;
          pc_d    = target_c;
          cnt_d   = CNT_W'(FLUSH_DEPTH);
          flush_d = 1'b1;
        end else if (!bus.stall) begin
          pc_d = pc_q + DATA_WIDTH'(4);
        end
      end
      PCU_FLUSH: begin
        if (!bus.stall) begin
          pc_d = pc_q + DATA_WIDTH'(4);
        end
        // Counter runs through stalls so the squash window stays fixed
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = PCU_RUN;
        end else begin
          flush_d = 1'b1;
        end
      end
      PCU_HALT: begin
        state_d = PCU_HALT;
      end
      default: begin
        state_d = PCU_RUN;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.flush       = flush_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.link_addr   = link_c;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken_q;
  logic [31:0] stat_flush_q;

  // A RUN->FLUSH transition is exactly one accepted redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken_q <= '0;
      stat_flush_q <= '0;
    end else begin
      if (state_q == PCU_RUN && state_d == PCU_FLUSH && stat_taken_q != '1) begin
        stat_taken_q <= stat_taken_q + 32'd1;
      end
      if (flush_q && stat_flush_q != '1) begin
        stat_flush_q <= stat_flush_q + 32'd1;
      end
    end
  end

  assign bus.stat_taken        = stat_taken_q;
  assign bus.stat_flush_cycles = stat_flush_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit with an event-timestamp reference model
// checked every cycle, plus literal expectations at key points.
module tb_pc_branch_unit;

  localparam int unsigned DW          = 32;
  localparam logic [31:0] RST_PC      = 32'h0000_0040;
  localparam int          FLUSH_D     = 2;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  pc_branch_unit_if #(.DATA_WIDTH(DW)) bus ();

  pc_branch_unit #(
    .DATA_WIDTH  (DW),
    .RESET_PC    (RST_PC),
    .FLUSH_DEPTH (FLUSH_D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: redirects/halt recorded as the edge number on which they were taken
  logic [31:0] m_pc;
  int          m_e;
  int          m_r;
  int          m_h;
  int          e_now;
  bit          m_acc;
  bit          exp_flush;
  bit          exp_halted;

  function automatic logic [31:0] model_target(input bit jal, input logic [31:0] epc,
                                               input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] t;
    if (jal) t = rs1 + imm * 32'd4;
    else     t = epc + 32'd4 + imm * 32'd4;
    return t & 32'hFFFF_FFFC;
  endfunction

  assign e_now      = m_e + 1;
  assign m_acc      = bus.ex_valid && (m_h < 0) &&
                      !(m_r >= 0 && e_now >= m_r + 1 && e_now <= m_r + FLUSH_D);
  assign exp_flush  = (m_r >= 0 && m_e >= m_r && m_e <= m_r + FLUSH_D - 1) ||
                      (m_h >= 0 && m_e == m_h);
  assign exp_halted = (m_h >= 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RST_PC;
      m_e  <= 0;
      m_r  <= -1;
      m_h  <= -1;
    end else begin
      m_e <= e_now;
      if (m_acc && bus.ex_is_halt) begin
        m_h <= e_now;
      end else if (m_acc && (bus.ex_is_jal || (bus.ex_is_branch && bus.alu_compare))) begin
        m_r  <= e_now;
        m_pc <= model_target(bus.ex_is_jal, bus.ex_pc, bus.ex_imm, bus.ex_rs1);
      end else if (m_h < 0 && !bus.stall) begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("pc", bus.pc, m_pc);
      check("flush", 32'(bus.flush), 32'(exp_flush));
      check("halted", 32'(bus.halted), 32'(exp_halted));
      check("fetch_valid", 32'(bus.fetch_valid), 32'(!exp_halted));
      check("link_addr", bus.link_addr, bus.ex_pc + 32'd4);
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
    bus.ex_is_jal    = 1'b0;
    bus.ex_is_halt   = 1'b0;
    bus.alu_compare  = 1'b0;
  endtask

  task automatic drive(input bit br, input bit jal, input bit halt, input bit cmp,
                       input logic [31:0] epc, input logic [31:0] imm, input logic [31:0] rs1);
    bus.ex_valid     = 1'b1;
    bus.ex_is_branch = br;
    bus.ex_is_jal    = jal;
    bus.ex_is_halt   = halt;
    bus.alu_compare  = cmp;
    bus.ex_pc        = epc;
    bus.ex_imm       = imm;
    bus.ex_rs1       = rs1;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.stall = 1'b0;
    idle_inputs();
    bus.ex_pc  = '0;
    bus.ex_imm = '0;
    bus.ex_rs1 = '0;
    repeat (2) next_cycle();
    check("rst_pc", bus.pc, 32'h40);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd1);
    rst_n = 1'b1;

    // Sequential fetch
    next_cycle(); check("seq_pc1", bus.pc, 32'h44);
    next_cycle(); check("seq_pc2", bus.pc, 32'h48);

    // Taken branch: 0x100 + 4 + 3*4
    drive(1, 0, 0, 1, 32'h100, 32'd3, 32'h0);
    next_cycle(); check("br_pc", bus.pc, 32'h110); check("br_flush1", 32'(bus.flush), 32'd1);
    idle_inputs();
    next_cycle(); check("br_pc2", bus.pc, 32'h114); check("br_flush2", 32'(bus.flush), 32'd1);
    next_cycle(); check("br_pc3", bus.pc, 32'h118); check("br_flush_end", 32'(bus.flush), 32'd0);

    // Not-taken branch
    drive(1, 0, 0, 0, 32'h200, 32'd5, 32'h0);
    next_cycle(); check("nt_pc", bus.pc, 32'h11C); check("nt_flush", 32'(bus.flush), 32'd0);

    // JAL with negative offset; link is combinational
    drive(0, 1, 0, 0, 32'h300, 32'hFFFF_FFFF, 32'h2002);
    #1 check("jal_link", bus.link_addr, 32'h304);
    next_cycle(); check("jal_pc", bus.pc, 32'h1FFC); check("jal_flush", 32'(bus.flush), 32'd1);
    idle_inputs();
    repeat (2) next_cycle();
    check("jal_after", bus.pc, 32'h2004);

    // Redirect under stall, then a wrong-path branch during FLUSH
    bus.stall = 1'b1;
    drive(1, 0, 0, 1, 32'h400, 32'd4, 32'h0);
    next_cycle(); check("stall_br_pc", bus.pc, 32'h414);
    drive(1, 0, 0, 1, 32'h800, 32'd8, 32'h0);
    next_cycle(); check("stall_fl_pc1", bus.pc, 32'h414); check("stall_fl1", 32'(bus.flush), 32'd1);
    next_cycle(); check("stall_fl_pc2", bus.pc, 32'h414); check("stall_fl_end", 32'(bus.flush), 32'd0);
    idle_inputs();
    bus.stall = 1'b0;

    // Wrap-around target
    drive(1, 0, 0, 1, 32'hFFFF_FFFC, 32'd0, 32'h0);
    next_cycle(); check("wrap_pc", bus.pc, 32'h0);
    idle_inputs();
    repeat (2) next_cycle();
    check("wrap_after", bus.pc, 32'h8);

    // Halt together with JAL: halt wins
    drive(0, 1, 1, 1, 32'h500, 32'd2, 32'h5000);
    next_cycle();
    check("halt_pc", bus.pc, 32'h8);
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_fetch", 32'(bus.fetch_valid), 32'd0);
    check("halt_flush", 32'(bus.flush), 32'd1);
    drive(0, 1, 0, 0, 32'h600, 32'd2, 32'h6000);
    next_cycle();
    check("halt_pc2", bus.pc, 32'h8);
    check("halt_flush2", 32'(bus.flush), 32'd0);
    idle_inputs();
    next_cycle();

    // Asynchronous reset while halted
    rst_n = 1'b0;
    #1;
    check("arst_pc", bus.pc, 32'h40);
    check("arst_halted", 32'(bus.halted), 32'd0);
    check("arst_fetch", 32'(bus.fetch_valid), 32'd1);
    check("arst_flush", 32'(bus.flush), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle(); check("post_rst_pc", bus.pc, 32'h44);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter and control-flow resolution stage of the CS3220 pipeline. It consumes the execute-stage ALU `compare` result plus decoded branch/jump information. It holds the architectural fetch PC, applies taken branches and JAL redirects, and squashes wrong-path instructions with a timed flush. It sits directly downstream of the ALU and upstream of the fetch stage.

## Interface
Parameters:
- DATA_WIDTH, 32, PC/operand width
- RESET_PC, 32'h0000_0040, PC value after reset
- FLUSH_DEPTH, 2, cycles flush is held after a redirect (1..7)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  pipeline hold; freezes PC increment
- ex_valid  input  1  execute-stage instruction valid
- ex_is_branch  input  1  instruction is a conditional branch
- ex_is_jal  input  1  instruction is JAL
- ex_is_halt  input  1  instruction halts the core
- alu_compare  input  1  ALU `compare` output for this instruction
- ex_pc  input  DATA_WIDTH  byte PC of the execute-stage instruction
- ex_imm  input  DATA_WIDTH  sign-extended word offset
- ex_rs1  input  DATA_WIDTH  JAL base register value
- pc  output  DATA_WIDTH  current fetch PC
- fetch_valid  output  1  fetch enabled this cycle
- flush  output  1  squash all instructions younger than execute
- link_addr  output  DATA_WIDTH  ex_pc + 4, for JAL writeback (combinational)
- halted  output  1  core halted

## Operation
- States: RUN, FLUSH, HALT. Reset values: state RUN, pc = RESET_PC, flush 0, halted 0, fetch_valid 1.
- An instruction is accepted only when `ex_valid` is high and the state is RUN. In FLUSH, `ex_*` inputs are ignored because they are wrong-path.
- Taken branch: accepted with `ex_is_branch & alu_compare`. Target = ex_pc + 4 + (ex_imm << 2).
- JAL: accepted with `ex_is_jal`, regardless of `alu_compare`. Target = ex_rs1 + (ex_imm << 2).
- Redirect: on either accepted case, pc <= target, state <= FLUSH, flush counter <= FLUSH_DEPTH.
- Arithmetic is modulo 2^DATA_WIDTH, so wrap-around is silent. Target bits [1:0] are forced to 0.
- RUN without a redirect:
  - If `stall` is low, pc <= pc + 4.
  - If `stall` is high, pc holds.
  - A redirect overrides `stall`.
- FLUSH:
  - `flush` = 1 and `fetch_valid` = 1.
  - pc <= pc + 4 unless stalled.
  - The counter decrements every cycle, including stalled cycles. At 1 the state goes to RUN.
- Halt: an accepted `ex_is_halt` moves the state to HALT.
  - pc freezes, fetch_valid = 0, halted = 1, flush = 1 for one cycle.
  - The only exit from HALT is reset.
- Priority when several are asserted together: halt > JAL > branch. A halt on the same cycle as a redirect suppresses the redirect.
- Reset mid-FLUSH or in HALT returns immediately (asynchronously) to the reset values.

## Timing
- A redirect accepted in cycle N gives pc = target in N+1 and `flush` high in N+1 … N+FLUSH_DEPTH. The state is RUN in N+FLUSH_DEPTH+1.
- A halt accepted in cycle N gives `halted` high from N+1. `flush` is high only in N+1.
- `link_addr` is combinational, with zero latency. All other outputs are registered.
- A back-to-back redirect is impossible, because inputs are ignored while in FLUSH.

## Configuration
- BRANCH_STATS_EN defined: adds outputs `stat_taken` (32 bits, counts accepted taken branches and JALs) and `stat_flush_cycles` (32 bits, counts cycles with flush = 1). Both counters reset to 0 and saturate at all-ones.
- BRANCH_STATS_EN undefined: neither the ports nor the counters exist, and all other behaviour is identical.

## Structure
- Shared package `cpu_pkg`: state encoding (PCU_RUN = 2'd0, PCU_FLUSH = 2'd1, PCU_HALT = 2'd2), DATA_WIDTH, RESET_PC.
- One sub-module, `pcu_target_calc`: combinational target and link computation (branch adder, JAL adder, bit-[1:0] masking).
- The FSM, PC register and flush counter live in the top level.

## Test plan
- Reset released, stall = 0 → pc sequence 0x40, 0x44, 0x48; flush = 0; fetch_valid = 1.
- Branch at ex_pc = 0x100, ex_imm = 3, alu_compare = 1 → next pc = 0x110; flush high for exactly 2 cycles.
- Branch with alu_compare = 0 → pc continues +4; flush stays 0.
- JAL with ex_rs1 = 0x2002, ex_imm = −1 → pc = 0x1FFC; link_addr = ex_pc + 4.
- Halt asserted on the same cycle as a JAL → no redirect; halted = 1 next cycle; pc frozen; fetch_valid = 0. Then rst_n low mid-HALT → pc = 0x40 immediately.
- Taken branch while stall = 1, then a second `ex_valid` branch during FLUSH → first redirect applied, second ignored; wrap test with ex_pc = 0xFFFFFFFC, ex_imm = 0 → pc = 0x0.
